// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back scheduler.
//   DATA_W   : write-data width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   req_e    : requester encoding used by the round-robin pointer
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between the EX and MEM write-back requesters.
//
// Ports:
//   clock, clear  : rising-edge clock, asynchronous active-low reset
//   ex_valid_i    : EX requests the write port
//   mem_valid_i   : MEM requests the write port
//   ex_ready_o    : EX granted this cycle (combinational)
//   mem_ready_o   : MEM granted this cycle (combinational)
//   gnt_valid_o   : some requester granted this cycle
//   gnt_sel_o     : which requester was granted (valid only with gnt_valid_o)
//   ptr_o         : priority pointer, the requester that wins a tie
//
// Handshake: a transfer happens in any cycle where valid and ready are both
// high; the requester keeps valid and payload stable until it sees ready.
// Ready never depends on anything but the two valids and the pointer, and at
// most one ready is high per cycle.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic ex_valid_i,
  input  logic mem_valid_i,
  output logic ex_ready_o,
  output logic mem_ready_o,
  output logic gnt_valid_o,
  output req_e gnt_sel_o,
  output req_e ptr_o
);

  req_e ptr_q, ptr_d;

  always_comb begin
    ex_ready_o  = ex_valid_i  & (~mem_valid_i | (ptr_q == REQ_EX));
    mem_ready_o = mem_valid_i & (~ex_valid_i  | (ptr_q == REQ_MEM));
    gnt_valid_o = ex_ready_o | mem_ready_o;
    gnt_sel_o   = mem_ready_o ? REQ_MEM : REQ_EX;
    // Every grant hands priority to the other side, so a requester that
    // keeps asking loses at most one tie in a row.
    ptr_d = ptr_q;
    if (ex_ready_o) begin
      ptr_d = REQ_MEM;
    end else if (mem_ready_o) begin
      ptr_d = REQ_EX;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ptr_q <= REQ_EX;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the single register-file write port between EX and MEM write-back,
// keeps a busy scoreboard of destinations with writes outstanding, and
// flags read-after-write hazards for the issue stage.
//
// Ports:
//   clock, clear            : rising-edge clock, asynchronous active-low reset
//   ex_valid/reg/data       : EX write-back request and payload
//   ex_ready                : EX request accepted this cycle
//   mem_valid/reg/data      : MEM write-back request and payload
//   mem_ready               : MEM request accepted this cycle
//   issue_valid/issue_reg   : issue stage reserving a destination register
//   issue_ready             : reservation accepted (destination not busy)
//   rs1, rs2                : sources of the issuing instruction
//   hazard                  : rs1 or rs2 has a pending write
//   busy_mask               : scoreboard, bit i = register i pending
//   rf_we/rf_waddr/rf_wdata : registered write controls to register_file
//   arb_ptr                 : arbiter priority pointer (observability)
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_reg,
  input  logic [DATA_W-1:0]   ex_data,
  output logic                ex_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_reg,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output req_e                arb_ptr
);

  logic                gnt_valid;
  req_e                gnt_sel;
  logic [ADDR_W-1:0]   gnt_reg;
  logic [DATA_W-1:0]   gnt_data;
  logic                issue_fire;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  wb_rr_arbiter u_arb (
    .clock       (clock),
    .clear       (clear),
    .ex_valid_i  (ex_valid),
    .mem_valid_i (mem_valid),
    .ex_ready_o  (ex_ready),
    .mem_ready_o (mem_ready),
    .gnt_valid_o (gnt_valid),
    .gnt_sel_o   (gnt_sel),
    .ptr_o       (arb_ptr)
  );

  always_comb begin
    gnt_reg  = (gnt_sel == REQ_MEM) ? mem_reg  : ex_reg;
    gnt_data = (gnt_sel == REQ_MEM) ? mem_data : ex_data;

    // A busy destination blocks the reservation, so at most one write per
    // register is ever outstanding and a single busy bit is enough.
    issue_ready = ~busy_q[issue_reg];
    issue_fire  = issue_valid & issue_ready;

    set_mask = '0;
    clr_mask = '0;
    if (issue_fire) set_mask[issue_reg] = 1'b1;
    if (gnt_valid)  clr_mask[gnt_reg]   = 1'b1;
    // Clear first, then set: a same-edge reservation survives the write-back.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    // Address and data only move on a grant; they hold while rf_we is low.
    we_d    = gnt_valid;
    waddr_d = gnt_valid ? gnt_reg  : waddr_q;
    wdata_d = gnt_valid ? gnt_data : wdata_q;

    // No bypass: the hazard reflects the registered mask only.
    hazard = busy_q[rs1] | busy_q[rs2];
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      busy_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_mask = busy_q;
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  logic                ex_valid, mem_valid, issue_valid;
  logic [ADDR_W-1:0]   ex_reg, mem_reg, issue_reg, rs1, rs2;
  logic [DATA_W-1:0]   ex_data, mem_data;
  logic                ex_ready, mem_ready, issue_ready, hazard;
  logic [NUM_REGS-1:0] busy_mask;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  req_e                arb_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_a;

  // Bench model of register_file, fed by the scheduler's write controls.
  logic [DATA_W-1:0] rf_model [NUM_REGS];
  always @(posedge clock) begin
    if (rf_we) rf_model[rf_waddr] <= rf_wdata;
  end

  regfile_wb_scheduler dut (
    .clock       (clock),
    .clear       (clear),
    .ex_valid    (ex_valid),
    .ex_reg      (ex_reg),
    .ex_data     (ex_data),
    .ex_ready    (ex_ready),
    .mem_valid   (mem_valid),
    .mem_reg     (mem_reg),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard      (hazard),
    .busy_mask   (busy_mask),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .arb_ptr     (arb_ptr)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ex_valid = 1'b0; ex_reg = '0; ex_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    issue_valid = 1'b0; issue_reg = '0;
    rs1 = '0; rs2 = '0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    clear = 1'b0;
    tick();
    tick();
    n_checks++; if (busy_mask !== 16'h0000) $display("FAIL reset_busy: got %h exp 0000", busy_mask); else n_pass++;
    n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b exp 0", rf_we); else n_pass++;
    n_checks++; if (rf_waddr !== 4'h0) $display("FAIL reset_waddr: got %h exp 0", rf_waddr); else n_pass++;
    n_checks++; if (rf_wdata !== 16'h0000) $display("FAIL reset_wdata: got %h exp 0000", rf_wdata); else n_pass++;
    n_checks++; if (arb_ptr !== REQ_EX) $display("FAIL reset_ptr: got %0d exp 0", arb_ptr); else n_pass++;
    clear = 1'b1;
    tick();
  endtask

  task automatic test_single_ex();
    ex_valid = 1'b1; ex_reg = 4'd3; ex_data = 16'h00A5;
    #1;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL single_ex_ready: got %b exp 1", ex_ready); else n_pass++;
    n_checks++; if (mem_ready !== 1'b0) $display("FAIL single_mem_ready: got %b exp 0", mem_ready); else n_pass++;
    tick();
    ex_valid = 1'b0; ex_reg = 4'd9; ex_data = 16'hDEAD;
    #1;
    n_checks++; if (rf_we !== 1'b1) $display("FAIL single_we: got %b exp 1", rf_we); else n_pass++;
    n_checks++; if (rf_waddr !== 4'd3) $display("FAIL single_waddr: got %h exp 3", rf_waddr); else n_pass++;
    n_checks++; if (rf_wdata !== 16'h00A5) $display("FAIL single_wdata: got %h exp 00a5", rf_wdata); else n_pass++;
    tick();
    n_checks++; if (rf_we !== 1'b0) $display("FAIL single_we_off: got %b exp 0", rf_we); else n_pass++;
    n_checks++; if (rf_waddr !== 4'd3) $display("FAIL single_waddr_hold: got %h exp 3", rf_waddr); else n_pass++;
    n_checks++; if (rf_wdata !== 16'h00A5) $display("FAIL single_wdata_hold: got %h exp 00a5", rf_wdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_valid = 1'b1; ex_reg = 4'd1; ex_data = 16'h0001;
    mem_valid = 1'b1; mem_reg = 4'd2; mem_data = 16'h0002;
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (ex_ready !== ((i % 2) == 0)) $display("FAIL b2b_ex_ready[%0d]: got %b exp %b", i, ex_ready, (i % 2) == 0); else n_pass++;
      n_checks++; if (mem_ready !== ((i % 2) == 1)) $display("FAIL b2b_mem_ready[%0d]: got %b exp %b", i, mem_ready, (i % 2) == 1); else n_pass++;
      tick();
      if (i == 3) begin
        ex_valid = 1'b0; mem_valid = 1'b0;
      end
      exp_a = exp_q.pop_front();
      n_checks++; if (rf_we !== 1'b1) $display("FAIL b2b_we[%0d]: got %b exp 1", i, rf_we); else n_pass++;
      n_checks++; if (rf_waddr !== exp_a) $display("FAIL b2b_waddr[%0d]: got %h exp %h", i, rf_waddr, exp_a); else n_pass++;
      n_checks++; if (rf_wdata !== 16'(exp_a)) $display("FAIL b2b_wdata[%0d]: got %h exp %h", i, rf_wdata, 16'(exp_a)); else n_pass++;
    end
    tick();
    n_checks++; if (rf_we !== 1'b0) $display("FAIL b2b_we_off: got %b exp 0", rf_we); else n_pass++;
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_reg = 4'd5;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL sb_issue_ready: got %b exp 1", issue_ready); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (busy_mask !== 16'h0020) $display("FAIL sb_busy_set: got %h exp 0020", busy_mask); else n_pass++;
    rs1 = 4'd5; rs2 = 4'd0;
    #1;
    n_checks++; if (hazard !== 1'b1) $display("FAIL sb_hazard_rs1: got %b exp 1", hazard); else n_pass++;
    rs1 = 4'd0; rs2 = 4'd0;
    #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL sb_hazard_none: got %b exp 0", hazard); else n_pass++;
    rs2 = 4'd5;
    #1;
    n_checks++; if (hazard !== 1'b1) $display("FAIL sb_hazard_rs2: got %b exp 1", hazard); else n_pass++;
    issue_valid = 1'b1; issue_reg = 4'd5;
    #1;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL sb_waw_block: got %b exp 0", issue_ready); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (busy_mask !== 16'h0020) $display("FAIL sb_busy_hold: got %h exp 0020", busy_mask); else n_pass++;
  endtask

  task automatic test_set_wins();
    // Reg 5 already busy. Reserve reg 6 in the same cycle MEM writes it back.
    mem_valid = 1'b1; mem_reg = 4'd6; mem_data = 16'h6666;
    issue_valid = 1'b1; issue_reg = 4'd6;
    rs1 = 4'd6; rs2 = 4'd6;
    #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL sw_mem_ready: got %b exp 1", mem_ready); else n_pass++;
    tick();
    mem_valid = 1'b0; issue_valid = 1'b0;
    n_checks++; if (busy_mask !== 16'h0060) $display("FAIL sw_busy: got %h exp 0060", busy_mask); else n_pass++;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd6) $display("FAIL sw_write: got we=%b addr=%h exp we=1 addr=6", rf_we, rf_waddr); else n_pass++;
    // Write-back to reg 5 clears it; write to non-busy reg 9 leaves it 0.
    ex_valid = 1'b1; ex_reg = 4'd5; ex_data = 16'h5555;
    tick();
    ex_reg = 4'd9; ex_data = 16'h9999;
    n_checks++; if (busy_mask !== 16'h0040) $display("FAIL sw_clear5: got %h exp 0040", busy_mask); else n_pass++;
    n_checks++; if (hazard !== 1'b1) $display("FAIL sw_hazard6: got %b exp 1", hazard); else n_pass++;
    tick();
    ex_valid = 1'b0;
    n_checks++; if (busy_mask !== 16'h0040) $display("FAIL sw_nonbusy: got %h exp 0040", busy_mask); else n_pass++;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 16'h9999) $display("FAIL sw_nonbusy_write: got we=%b addr=%h data=%h exp 1/9/9999", rf_we, rf_waddr, rf_wdata); else n_pass++;
    rs1 = 4'd0; rs2 = 4'd0;
  endtask

  task automatic test_same_reg();
    do_reset();
    ex_valid = 1'b1; ex_reg = 4'd7; ex_data = 16'h1111;
    mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'h2222;
    #1;
    n_checks++; if (ex_ready !== 1'b1 || mem_ready !== 1'b0) $display("FAIL same_first: got ex=%b mem=%b exp ex=1 mem=0", ex_ready, mem_ready); else n_pass++;
    tick();
    ex_valid = 1'b0;
    n_checks++; if (rf_wdata !== 16'h1111) $display("FAIL same_wdata1: got %h exp 1111", rf_wdata); else n_pass++;
    #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL same_mem_ready: got %b exp 1", mem_ready); else n_pass++;
    tick();
    mem_valid = 1'b0;
    n_checks++; if (rf_wdata !== 16'h2222 || rf_waddr !== 4'd7) $display("FAIL same_wdata2: got addr=%h data=%h exp 7/2222", rf_waddr, rf_wdata); else n_pass++;
    tick();
    n_checks++; if (rf_model[7] !== 16'h2222) $display("FAIL same_rf7: got %h exp 2222", rf_model[7]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 4; r < 8; r++) begin
      issue_valid = 1'b1; issue_reg = 4'(r);
      if (r == 7) begin
        ex_valid = 1'b1; ex_reg = 4'd12; ex_data = 16'h0C0C;
      end
      tick();
    end
    issue_valid = 1'b0;
    ex_reg = 4'd13; ex_data = 16'h0D0D;
    mem_valid = 1'b1; mem_reg = 4'd14; mem_data = 16'h0E0E;
    #1;
    n_checks++; if (busy_mask !== 16'h00F0) $display("FAIL mid_pre_busy: got %h exp 00f0", busy_mask); else n_pass++;
    n_checks++; if (rf_we !== 1'b1 || mem_ready !== 1'b1) $display("FAIL mid_pre_grant: got we=%b mem_ready=%b exp 1/1", rf_we, mem_ready); else n_pass++;
    clear = 1'b0;
    #1;
    n_checks++; if (busy_mask !== 16'h0000) $display("FAIL mid_busy: got %h exp 0000", busy_mask); else n_pass++;
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 16'h0) $display("FAIL mid_rf: got we=%b addr=%h data=%h exp 0/0/0", rf_we, rf_waddr, rf_wdata); else n_pass++;
    tick();
    clear = 1'b1;
    #2;
    n_checks++; if (ex_ready !== 1'b1 || mem_ready !== 1'b0) $display("FAIL mid_first_ex: got ex=%b mem=%b exp ex=1 mem=0", ex_ready, mem_ready); else n_pass++;
    tick();
    ex_valid = 1'b0; mem_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd13 || rf_wdata !== 16'h0D0D) $display("FAIL mid_after: got we=%b addr=%h data=%h exp 1/d/0d0d", rf_we, rf_waddr, rf_wdata); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_ex();
    test_back_to_back();
    test_scoreboard();
    test_set_wins();
    test_same_reg();
    test_reset_mid();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
